msi_l1_cache_ctrl: RTL and testbench
====================================

MSI_L1_CACHE_CTRL -- requirements
Module: msi_l1_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3: direct-mapped line index width, 2**INDEX_BITS lines; tag = address[8:INDEX_BITS].
REQ-002 SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- core_req_valid  in  1  core request present.
- core_write  in  1  1 = write, 0 = read.
- core_addr  in  9  word address.
- core_wdata  in  32  write data.
- core_ready  out  1  request accepted this cycle.
- core_rvalid  out  1  read data valid.
- core_rdata  out  32  read data.
- bus_req  out  1  bus request.
- bus_grant  in  1  bus granted.
- bus_cmd  out  2  00 Flush, 01 BusRd, 10 BusRdX, 11 BusUpgr.
- bus_addr  out  9  transaction address.
- bus_wdata  out  32  Flush data.
- bus_ack  in  1  transaction done.
- bus_rdata  in  32  fill data, valid with bus_ack.
- snoop_valid  in  1  another cache's transaction is on the bus.
- snoop_cmd  in  2  encoded as bus_cmd.
- snoop_addr  in  9  snooped address.
- snoop_flush  out  1  this cache supplies data.
- snoop_data  out  32  supplied data.

Function
REQ-003 Each line SHALL hold state I/S/M, tag and 32-bit data; hit = state != I and tag match.
REQ-004 Controller FSM SHALL have states IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPG_REQ, UPG_WAIT.
REQ-005 core_ready SHALL be 1 exactly when FSM is in IDLE; a request is accepted when core_req_valid and core_ready.
REQ-006 Read hit SHALL assert core_rvalid with line data on the next cycle; FSM stays in IDLE.
REQ-007 Write hit in M SHALL update line data at the accepting edge; FSM stays in IDLE; zero stall.
REQ-008 Write hit in S SHALL go to UPG_REQ.
REQ-009 Any miss whose victim line is M SHALL go to WB_REQ; any other miss SHALL go to FILL_REQ.
REQ-010 The accepted address, write flag and wdata SHALL be latched at acceptance.
REQ-011 While in any *_REQ state, bus_req SHALL be 1; bus_cmd and bus_addr SHALL be valid.
- WB: Flush, victim address, victim data on bus_wdata.
- FILL: BusRd on read, BusRdX on write.
- UPG: BusUpgr.
REQ-012 bus_grant SHALL move *_REQ to the matching *_WAIT; bus_req stays 1 until bus_ack.
REQ-013 On bus_ack:
- WB_WAIT SHALL set the victim to I and go to FILL_REQ.
- FILL_WAIT SHALL install the tag. A read installs bus_rdata in S and asserts core_rvalid/core_rdata=bus_rdata the next cycle. A write installs the latched wdata in M. Then IDLE.
- UPG_WAIT SHALL write the latched data, set M, then IDLE.
REQ-014 Snoop hit SHALL be snoop_valid, snoop_addr hit, and snoop_cmd != Flush.
- In M, snoop_flush=1 and snoop_data=line data, combinationally, same cycle.
- BusRd SHALL change M to S.
- BusRdX and BusUpgr SHALL change S or M to I.
- All other cases leave state unchanged and snoop_flush=0.
REQ-015 A snoop and a local update to the same line on one edge SHALL apply the local update after the snoop; the local update wins.
REQ-016 If a snoop invalidates the pending line while in UPG_REQ, FSM SHALL switch to FILL_REQ with BusRdX, not BusUpgr; in UPG_WAIT the snoop SHALL be ignored.
REQ-017 A snoop invalidating the victim during WB_REQ SHALL abort the writeback and go directly to FILL_REQ.
REQ-018 core_rvalid SHALL be a single-cycle pulse; outputs not specified above SHALL be 0.

Reset
REQ-019 rst_n low SHALL immediately, at any point including mid-transaction, set every line to I, set FSM to IDLE, and drive bus_req, core_rvalid and snoop_flush to 0, bus_cmd to 00, core_rdata and snoop_data to 0, and core_ready to 1.

Verification
REQ-020 Scenarios:
- Read 0x015 cold -> BusRd addr 0x015; ack with 0xDEADBEEF -> rvalid, rdata 0xDEADBEEF; reread 0x015 -> rvalid next cycle, no bus_req.
- Write 0x015 after the above (line in S) -> BusUpgr; after ack, line M; snoop BusRd 0x015 -> snoop_flush=1, snoop_data=new data, line S.
- Write 0x00D (M) then read 0x005 (same index) -> Flush 0x00D with data, then BusRd 0x005.
- In UPG_REQ, snoop BusRdX same address -> bus_cmd becomes BusRdX, completes in M.
- Back-to-back write hits in M on 3 cycles -> core_ready stays 1, bus_req stays 0.
- rst_n low during FILL_WAIT -> bus_req 0, core_ready 1, reread of the same address misses.

Source files
------------

// File: rtl/msi_l1_cache_ctrl.sv
// Direct-mapped L1 cache controller with MSI coherence.
// One outstanding core request; bus transactions are Flush (writeback),
// BusRd / BusRdX (fill) and BusUpgr (S->M upgrade). Snoops are applied
// to the line array every cycle, ahead of any local update.
module msi_l1_cache_ctrl #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_valid,
  input  logic        core_write,
  input  logic [8:0]  core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ready,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [1:0]  bus_cmd,
  output logic [8:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        snoop_valid,
  input  logic [1:0]  snoop_cmd,
  input  logic [8:0]  snoop_addr,
  output logic        snoop_flush,
  output logic [31:0] snoop_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 9 - INDEX_BITS;

  localparam logic [1:0] LS_I = 2'd0;
  localparam logic [1:0] LS_S = 2'd1;
  localparam logic [1:0] LS_M = 2'd2;

  localparam logic [1:0] CMD_FLUSH = 2'b00;
  localparam logic [1:0] CMD_RD    = 2'b01;
  localparam logic [1:0] CMD_RDX   = 2'b10;
  localparam logic [1:0] CMD_UPG   = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB_REQ    = 3'd1;
  localparam logic [2:0] ST_WB_WAIT   = 3'd2;
  localparam logic [2:0] ST_FILL_REQ  = 3'd3;
  localparam logic [2:0] ST_FILL_WAIT = 3'd4;
  localparam logic [2:0] ST_UPG_REQ   = 3'd5;
  localparam logic [2:0] ST_UPG_WAIT  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       lstate_q [LINES];
  logic [1:0]       lstate_d [LINES];
  logic [TAG_W-1:0] ltag_q   [LINES];
  logic [TAG_W-1:0] ltag_d   [LINES];
  logic [31:0]      ldata_q  [LINES];
  logic [31:0]      ldata_d  [LINES];
  logic [8:0]       req_addr_q, req_addr_d;
  logic             req_write_q, req_write_d;
  logic [31:0]      req_wdata_q, req_wdata_d;

  logic [INDEX_BITS-1:0] core_idx, req_idx, snp_idx;
  logic [TAG_W-1:0]      core_tag, req_tag, snp_tag;
  logic                  core_hit, pend_hit;
  logic                  snp_hit, snp_inval, snp_down, snp_kill_pend;

  assign core_idx = core_addr[INDEX_BITS-1:0];
  assign core_tag = core_addr[8:INDEX_BITS];
  assign req_idx  = req_addr_q[INDEX_BITS-1:0];
  assign req_tag  = req_addr_q[8:INDEX_BITS];
  assign snp_idx  = snoop_addr[INDEX_BITS-1:0];
  assign snp_tag  = snoop_addr[8:INDEX_BITS];

  // Hit detection for the core request, pending line and snooped address
  always_comb begin
    core_hit      = (lstate_q[core_idx] != LS_I) && (ltag_q[core_idx] == core_tag);
    pend_hit      = (lstate_q[req_idx] != LS_I) && (ltag_q[req_idx] == req_tag);
    snp_hit       = snoop_valid && (snoop_cmd != CMD_FLUSH) &&
                    (lstate_q[snp_idx] != LS_I) && (ltag_q[snp_idx] == snp_tag);
    snp_inval     = snp_hit && ((snoop_cmd == CMD_RDX) || (snoop_cmd == CMD_UPG));
    snp_down      = snp_hit && (snoop_cmd == CMD_RD) && (lstate_q[snp_idx] == LS_M);
    // Line at the pending index is being invalidated (victim or upgrade target)
    snp_kill_pend = snp_inval && (snp_idx == req_idx);
  end

  // Snoop response: supply the dirty line in the same cycle
  always_comb begin
    snoop_flush = snp_hit && (lstate_q[snp_idx] == LS_M);
    snoop_data  = snoop_flush ? ldata_q[snp_idx] : 32'd0;
  end

  // Next-state: snoop effects first, then local updates override them
  always_comb begin
    state_d     = state_q;
    rvalid_d    = 1'b0;
    rdata_d     = 32'd0;
    lstate_d    = lstate_q;
    ltag_d      = ltag_q;
    ldata_d     = ldata_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;

    if (snp_inval) begin
      lstate_d[snp_idx] = LS_I;
    end else if (snp_down) begin
      lstate_d[snp_idx] = LS_S;
    end

    case (state_q)
      ST_IDLE: begin
        if (core_req_valid) begin
          req_addr_d  = core_addr;
          req_write_d = core_write;
          req_wdata_d = core_wdata;
          if (core_hit) begin
            if (!core_write) begin
              rvalid_d = 1'b1;
              rdata_d  = ldata_q[core_idx];
            end else if (lstate_q[core_idx] == LS_M) begin
              ldata_d[core_idx]  = core_wdata;
              lstate_d[core_idx] = LS_M;
            end else begin
              state_d = ST_UPG_REQ;
            end
          end else if (lstate_q[core_idx] == LS_M) begin
            state_d = ST_WB_REQ;
          end else begin
            state_d = ST_FILL_REQ;
          end
        end
      end
      ST_WB_REQ: begin
        // Victim lost its dirty copy to a snoop: nothing left to write back
        if (snp_kill_pend || (lstate_q[req_idx] != LS_M)) begin
          state_d = ST_FILL_REQ;
        end else if (bus_grant) begin
          state_d = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (bus_ack) begin
          lstate_d[req_idx] = LS_I;
          state_d           = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        if (bus_grant) begin
          state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (bus_ack) begin
          ltag_d[req_idx] = req_tag;
          if (req_write_q) begin
            lstate_d[req_idx] = LS_M;
            ldata_d[req_idx]  = req_wdata_q;
          end else begin
            lstate_d[req_idx] = LS_S;
            ldata_d[req_idx]  = bus_rdata;
            rvalid_d          = 1'b1;
            rdata_d           = bus_rdata;
          end
          state_d = ST_IDLE;
        end
      end
      ST_UPG_REQ: begin
        // Shared copy gone: upgrade is no longer possible, fetch exclusively
        if (snp_kill_pend || !pend_hit) begin
          state_d = ST_FILL_REQ;
        end else if (bus_grant) begin
          state_d = ST_UPG_WAIT;
        end
      end
      ST_UPG_WAIT: begin
        if (bus_ack) begin
          ltag_d[req_idx]   = req_tag;
          ldata_d[req_idx]  = req_wdata_q;
          lstate_d[req_idx] = LS_M;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and core outputs decoded from the controller state
  always_comb begin
    core_ready  = (state_q == ST_IDLE);
    core_rvalid = rvalid_q;
    core_rdata  = rdata_q;
    bus_req     = 1'b0;
    bus_cmd     = CMD_FLUSH;
    bus_addr    = 9'd0;
    bus_wdata   = 32'd0;
    case (state_q)
      ST_WB_REQ, ST_WB_WAIT: begin
        bus_req   = 1'b1;
        bus_cmd   = CMD_FLUSH;
        bus_addr  = {ltag_q[req_idx], req_idx};
        bus_wdata = ldata_q[req_idx];
      end
      ST_FILL_REQ, ST_FILL_WAIT: begin
        bus_req  = 1'b1;
        bus_cmd  = req_write_q ? CMD_RDX : CMD_RD;
        bus_addr = req_addr_q;
      end
      ST_UPG_REQ, ST_UPG_WAIT: begin
        bus_req  = 1'b1;
        bus_cmd  = CMD_UPG;
        bus_addr = req_addr_q;
      end
      default: ;
    endcase
  end

  // Control state: FSM, read-return register and line coherence states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      for (int i = 0; i < LINES; i++) begin
        lstate_q[i] <= LS_I;
      end
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      lstate_q <= lstate_d;
    end
  end

  // Tag/data arrays and request latches; only meaningful under a valid state
  always_ff @(posedge clk) begin
    ltag_q      <= ltag_d;
    ldata_q     <= ldata_d;
    req_addr_q  <= req_addr_d;
    req_write_q <= req_write_d;
    req_wdata_q <= req_wdata_d;
  end

endmodule

// File: tb/tb_msi_l1_cache_ctrl.sv
// Self-checking bench for msi_l1_cache_ctrl: read data goes through a
// scoreboard queue; bus and snoop behaviour is checked inline per scenario.
module tb_msi_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_valid, core_write;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_ready, core_rvalid;
  logic [31:0] core_rdata;
  logic        bus_req, bus_grant, bus_ack;
  logic [1:0]  bus_cmd;
  logic [8:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        snoop_valid;
  logic [1:0]  snoop_cmd;
  logic [8:0]  snoop_addr;
  logic        snoop_flush;
  logic [31:0] snoop_data;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  msi_l1_cache_ctrl #(.INDEX_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_flush(snoop_flush), .snoop_data(snoop_data)
  );

  always #5 clk = ~clk;

  // Read-data scoreboard
  always @(negedge clk) begin
    if (core_rvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: got rvalid with rdata=%h, required no rvalid", core_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (core_rdata !== mon_exp) begin
          bad++;
          $display("FAIL rdata: got %h, required %h", core_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one core request for one cycle; returns at the negedge after acceptance
  task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    core_req_valid = 1'b1;
    core_write     = w;
    core_addr      = a;
    core_wdata     = d;
    @(negedge clk);
    core_req_valid = 1'b0;
  endtask

  // Act as bus arbiter/memory for one transaction, checking the request fields
  task automatic serve_bus(input logic [1:0] ecmd, input logic [8:0] eaddr,
                           input logic chk_wd, input logic [31:0] ewd,
                           input logic [31:0] rd);
    int n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus_req) begin
      bad++;
      $display("FAIL bus_req_timeout: got bus_req=0, required 1 (cmd %0d addr %h)", ecmd, eaddr);
      return;
    end
    total++;
    if (bus_cmd !== ecmd || bus_addr !== eaddr) begin
      bad++;
      $display("FAIL bus_request: got cmd=%0d addr=%h, required cmd=%0d addr=%h",
               bus_cmd, bus_addr, ecmd, eaddr);
    end
    if (chk_wd) begin
      total++;
      if (bus_wdata !== ewd) begin
        bad++;
        $display("FAIL bus_wdata: got %h, required %h", bus_wdata, ewd);
      end
    end
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    total++;
    if (bus_req !== 1'b1 || bus_cmd !== ecmd) begin
      bad++;
      $display("FAIL bus_wait_hold: got req=%b cmd=%0d, required req=1 cmd=%0d", bus_req, bus_cmd, ecmd);
    end
    bus_ack   = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (core_ready !== 1'b1 || bus_req !== 1'b0 || core_rvalid !== 1'b0 ||
        snoop_flush !== 1'b0 || bus_cmd !== 2'b00 || core_rdata !== 32'd0 || snoop_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b req=%b rvalid=%b flush=%b cmd=%0d rdata=%h sdata=%h, required 1 0 0 0 0 0 0",
               core_ready, bus_req, core_rvalid, snoop_flush, bus_cmd, core_rdata, snoop_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    issue(1'b0, 9'h015, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    serve_bus(2'b01, 9'h015, 1'b0, 32'd0, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b0, 9'h015, 32'd0);
    total++;
    if (core_rvalid !== 1'b1 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL read_hit: got rvalid=%b bus_req=%b, required rvalid=1 bus_req=0", core_rvalid, bus_req);
    end
  endtask

  task automatic test_upgrade_and_snoop();
    issue(1'b1, 9'h015, 32'h12345678);
    serve_bus(2'b11, 9'h015, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_cmd = 2'b01; snoop_addr = 9'h015;
    #1;
    total++;
    if (snoop_flush !== 1'b1 || snoop_data !== 32'h12345678) begin
      bad++;
      $display("FAIL snoop_flush_m: got flush=%b data=%h, required flush=1 data=12345678", snoop_flush, snoop_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (snoop_flush !== 1'b0 || snoop_data !== 32'd0) begin
      bad++;
      $display("FAIL snoop_after_downgrade: got flush=%b data=%h, required flush=0 data=0", snoop_flush, snoop_data);
    end
    snoop_valid = 1'b0;
    exp_q.push_back(32'h12345678);
    issue(1'b0, 9'h015, 32'd0);
    total++;
    if (bus_req !== 1'b0) begin
      bad++;
      $display("FAIL shared_read_hit: got bus_req=%b, required 0", bus_req);
    end
  endtask

  task automatic test_writeback();
    issue(1'b1, 9'h00D, 32'hA5A50001);
    serve_bus(2'b10, 9'h00D, 1'b0, 32'd0, 32'h0);
    exp_q.push_back(32'h0BADF00D);
    issue(1'b0, 9'h005, 32'd0);
    serve_bus(2'b00, 9'h00D, 1'b1, 32'hA5A50001, 32'd0);
    serve_bus(2'b01, 9'h005, 1'b0, 32'd0, 32'h0BADF00D);
  endtask

  task automatic test_upg_snooped();
    issue(1'b1, 9'h005, 32'h5555AAAA);
    total++;
    if (bus_req !== 1'b1 || bus_cmd !== 2'b11) begin
      bad++;
      $display("FAIL upg_request: got req=%b cmd=%0d, required req=1 cmd=3", bus_req, bus_cmd);
    end
    snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_addr = 9'h005;
    @(negedge clk);
    snoop_valid = 1'b0;
    total++;
    if (bus_cmd !== 2'b10 || bus_addr !== 9'h005) begin
      bad++;
      $display("FAIL upg_to_rdx: got cmd=%0d addr=%h, required cmd=2 addr=005", bus_cmd, bus_addr);
    end
    serve_bus(2'b10, 9'h005, 1'b0, 32'd0, 32'h0);
    snoop_valid = 1'b1; snoop_cmd = 2'b01; snoop_addr = 9'h005;
    #1;
    total++;
    if (snoop_flush !== 1'b1 || snoop_data !== 32'h5555AAAA) begin
      bad++;
      $display("FAIL rdx_installs_m: got flush=%b data=%h, required flush=1 data=5555aaaa", snoop_flush, snoop_data);
    end
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 9'h0E2, 32'h1);
    serve_bus(2'b10, 9'h0E2, 1'b0, 32'd0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      core_req_valid = 1'b1; core_write = 1'b1; core_addr = 9'h0E2; core_wdata = 32'h100 * i;
      #1;
      total++;
      if (core_ready !== 1'b1 || bus_req !== 1'b0) begin
        bad++;
        $display("FAIL b2b_write_%0d: got ready=%b req=%b, required ready=1 req=0", i, core_ready, bus_req);
      end
    end
    @(negedge clk);
    core_req_valid = 1'b0;
    total++;
    if (core_ready !== 1'b1 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after: got ready=%b req=%b, required ready=1 req=0", core_ready, bus_req);
    end
    exp_q.push_back(32'h300);
    issue(1'b0, 9'h0E2, 32'd0);
  endtask

  task automatic test_reset_mid_fill();
    issue(1'b0, 9'h033, 32'd0);
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL fill_wait_req: got bus_req=%b, required 1", bus_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_req !== 1'b0 || core_ready !== 1'b1 || bus_cmd !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_fill: got req=%b ready=%b cmd=%0d, required req=0 ready=1 cmd=0",
               bus_req, core_ready, bus_cmd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 9'h033, 32'd0);
    total++;
    if (bus_req !== 1'b1 || bus_cmd !== 2'b01 || core_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reread_after_reset: got req=%b cmd=%0d rvalid=%b, required req=1 cmd=1 rvalid=0",
               bus_req, bus_cmd, core_rvalid);
    end
    exp_q.push_back(32'h33330000);
    serve_bus(2'b01, 9'h033, 1'b0, 32'd0, 32'h33330000);
  endtask

  task automatic test_wb_abort();
    issue(1'b1, 9'h044, 32'h00000044);
    serve_bus(2'b10, 9'h044, 1'b0, 32'd0, 32'h0);
    issue(1'b0, 9'h04C, 32'd0);
    total++;
    if (bus_cmd !== 2'b00 || bus_addr !== 9'h044 || bus_wdata !== 32'h44) begin
      bad++;
      $display("FAIL wb_request: got cmd=%0d addr=%h wdata=%h, required cmd=0 addr=044 wdata=00000044",
               bus_cmd, bus_addr, bus_wdata);
    end
    snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_addr = 9'h044;
    #1;
    total++;
    if (snoop_flush !== 1'b1 || snoop_data !== 32'h44) begin
      bad++;
      $display("FAIL wb_snoop_flush: got flush=%b data=%h, required flush=1 data=00000044", snoop_flush, snoop_data);
    end
    @(negedge clk);
    snoop_valid = 1'b0;
    total++;
    if (bus_cmd !== 2'b01 || bus_addr !== 9'h04C) begin
      bad++;
      $display("FAIL wb_abort: got cmd=%0d addr=%h, required cmd=1 addr=04c", bus_cmd, bus_addr);
    end
    exp_q.push_back(32'h4C4C4C4C);
    serve_bus(2'b01, 9'h04C, 1'b0, 32'd0, 32'h4C4C4C4C);
  endtask

  initial begin
    core_req_valid = 1'b0; core_write = 1'b0; core_addr = 9'd0; core_wdata = 32'd0;
    bus_grant = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    snoop_valid = 1'b0; snoop_cmd = 2'b00; snoop_addr = 9'd0;
    test_reset();
    test_read_miss_hit();
    test_upgrade_and_snoop();
    test_writeback();
    test_upg_snooped();
    test_back_to_back();
    test_reset_mid_fill();
    test_wb_abort();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_reads: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
